// File: rtl/led_activity_ctrl.sv
// Multi-port front-panel LED controller: shared blink generator with phase sync,
// per-port activity stretching, mode overrides, lamp test and selectable pin polarity.
module led_activity_ctrl #(
    parameter int unsigned NPORT          = 8,
    parameter int unsigned BLINK_DIV      = 1024,
    parameter int unsigned ACT_HOLD       = 4096,
    parameter bit          LED_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NPORT-1:0]   link_up_i,
    input  logic [NPORT-1:0]   act_i,
    input  logic [2*NPORT-1:0] mode_i,
    input  logic               lamp_test_i,
    input  logic               blink_sync_i,
    output logic               blink_ph_o,
    output logic [NPORT-1:0]   led_o
);

    localparam int unsigned DivW  = $clog2(BLINK_DIV);
    localparam int unsigned HoldW = $clog2(ACT_HOLD + 1);

    localparam logic [DivW-1:0]  DivMax   = DivW'(BLINK_DIV - 1);
    localparam logic [HoldW-1:0] HoldLoad = HoldW'(ACT_HOLD);

    typedef enum logic [1:0] {
        ModeAuto  = 2'b00,
        ModeOff   = 2'b01,
        ModeOn    = 2'b10,
        ModeBlink = 2'b11
    } mode_e;

    logic [DivW-1:0]             div_cnt_q, div_cnt_d;
    logic                        blink_ph_q, blink_ph_d;
    logic [NPORT-1:0][HoldW-1:0] hold_cnt_q, hold_cnt_d;
    logic [NPORT-1:0]            led_q, led_d;
    logic [NPORT-1:0]            active;
    logic [NPORT-1:0]            lit;

    // Sync takes priority over the natural wrap, so a coincident wrap does not toggle.
    always_comb begin
        div_cnt_d  = div_cnt_q + DivW'(1);
        blink_ph_d = blink_ph_q;
        if (blink_sync_i) begin
            div_cnt_d  = '0;
            blink_ph_d = 1'b1;
        end else if (div_cnt_q == DivMax) begin
            div_cnt_d  = '0;
            blink_ph_d = ~blink_ph_q;
        end
    end

    // Stretchers keep running under overrides so auto mode resumes with true history.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        active     = '0;
        lit        = '0;
        led_d      = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (!link_up_i[i]) begin
                hold_cnt_d[i] = '0;
            end else if (act_i[i]) begin
                hold_cnt_d[i] = HoldLoad;
            end else if (hold_cnt_q[i] != '0) begin
                hold_cnt_d[i] = hold_cnt_q[i] - HoldW'(1);
            end

            active[i] = link_up_i[i] & (act_i[i] | (hold_cnt_q[i] != '0));

            unique case (mode_e'(mode_i[2*i +: 2]))
                ModeOff:   lit[i] = 1'b0;
                ModeOn:    lit[i] = 1'b1;
                ModeBlink: lit[i] = blink_ph_q;
                ModeAuto:  lit[i] = link_up_i[i] & (active[i] ? blink_ph_q : 1'b1);
            endcase

            if (lamp_test_i) begin
                lit[i] = 1'b1;
            end

            led_d[i] = lit[i] ^ LED_ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q  <= '0;
            blink_ph_q <= 1'b0;
            hold_cnt_q <= '0;
            led_q      <= {NPORT{LED_ACTIVE_LOW}};
        end else begin
            div_cnt_q  <= div_cnt_d;
            blink_ph_q <= blink_ph_d;
            hold_cnt_q <= hold_cnt_d;
            led_q      <= led_d;
        end
    end

    assign blink_ph_o = blink_ph_q;
    assign led_o      = led_q;

endmodule

// File: tb/tb_led_activity_ctrl.sv
// Randomised scoreboard bench for led_activity_ctrl: an 8-port active-low instance and a
// 1-port active-high instance share stimulus and are checked against a cycle-count model.
module tb_led_activity_ctrl;

    localparam int NP = 8;
    localparam int BD = 4;
    localparam int AH = 10;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NP-1:0]   link_up, act;
    logic [2*NP-1:0] mode;
    logic            lamp_test, blink_sync;
    logic            bp, bp2;
    logic [NP-1:0]   led;
    logic [0:0]      led2;

    always #5 clk = ~clk;

    led_activity_ctrl #(
        .NPORT(NP), .BLINK_DIV(BD), .ACT_HOLD(AH), .LED_ACTIVE_LOW(1'b1)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .link_up_i(link_up), .act_i(act), .mode_i(mode),
        .lamp_test_i(lamp_test), .blink_sync_i(blink_sync), .blink_ph_o(bp), .led_o(led)
    );

    led_activity_ctrl #(
        .NPORT(1), .BLINK_DIV(BD), .ACT_HOLD(AH), .LED_ACTIVE_LOW(1'b0)
    ) u_dut_pol0 (
        .clk(clk), .rst_n(rst_n), .link_up_i(link_up[0:0]), .act_i(act[0:0]),
        .mode_i(mode[1:0]), .lamp_test_i(lamp_test), .blink_sync_i(blink_sync),
        .blink_ph_o(bp2), .led_o(led2)
    );

    typedef struct {
        logic [NP-1:0] led;
        logic          bp;
        logic          lit0;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase from edges elapsed since the last reset/sync reference point,
    // activity from the cycle of the last act seen with the link continuously up.
    int   cyc = 0;
    int   m_edges = 0;
    bit   ph_ref = 1'b0;
    int   last_act[NP];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic model_step();
        exp_t          e;
        logic [NP-1:0] lit;
        bit            ph_now, actv;
        lit = '0;
        if (!rst_n) begin
            m_edges = 0;
            ph_ref  = 1'b0;
            for (int i = 0; i < NP; i++) last_act[i] = -1000;
            e.led  = '1;
            e.bp   = 1'b0;
            e.lit0 = 1'b0;
        end else begin
            ph_now = ph_ref ^ (((m_edges / BD) % 2) == 1);
            for (int i = 0; i < NP; i++) begin
                actv = link_up[i] && (act[i] || (cyc - last_act[i] <= AH));
                case (mode[2*i +: 2])
                    2'b01:   lit[i] = 1'b0;
                    2'b10:   lit[i] = 1'b1;
                    2'b11:   lit[i] = ph_now;
                    default: lit[i] = !link_up[i] ? 1'b0 : (actv ? ph_now : 1'b1);
                endcase
                if (lamp_test) lit[i] = 1'b1;
                if (!link_up[i]) last_act[i] = -1000;
                else if (act[i]) last_act[i] = cyc;
            end
            if (blink_sync) begin
                ph_ref  = 1'b1;
                m_edges = 0;
            end else begin
                m_edges++;
            end
            e.bp   = ph_ref ^ (((m_edges / BD) % 2) == 1);
            e.led  = ~lit;
            e.lit0 = lit[0];
        end
        cyc++;
        exp_q.push_back(e);
    endtask

    task automatic apply(input bit rs, input logic [NP-1:0] lk, input logic [NP-1:0] ac,
                         input logic [2*NP-1:0] md, input bit lt, input bit sy);
        bit fall;
        @(negedge clk);
        fall       = rst_n && !rs;
        rst_n      = rs;
        link_up    = lk;
        act        = ac;
        mode       = md;
        lamp_test  = lt;
        blink_sync = sy;
        model_step();
        if (fall) begin
            #1;
            check("async_rst_led", 32'(led), 32'hFF);
            check("async_rst_blink_ph", 32'(bp), 32'd0);
            check("async_rst_led_pol0", 32'(led2), 32'd0);
        end
    endtask

    // Monitor: every clock the DUTs present a new registered output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("led", 32'(led), 32'(e.led));
                check("blink_ph", 32'(bp), 32'(e.bp));
                check("led_pol0", 32'(led2), 32'(e.lit0));
                check("blink_ph_pol0", 32'(bp2), 32'(e.bp));
            end
        end
    end

    initial begin
        logic [NP-1:0]   lk, ac;
        logic [2*NP-1:0] md;
        bit              lt, sy, rs;
        rst_n = 1'b0; link_up = '0; act = '0; mode = '0; lamp_test = 1'b0; blink_sync = 1'b0;
        for (int i = 0; i < NP; i++) last_act[i] = -1000;

        repeat (3) apply(1'b0, '0, '0, '0, 1'b0, 1'b0);

        // Auto mode on port 0: steady, one pulse, then a retrigger 5 cycles later.
        for (int c = 0; c < 40; c++)
            apply(1'b1, 8'h01, (c == 5 || c == 10) ? 8'h01 : 8'h00, '0, 1'b0, 1'b0);

        // Link drop on port 2 mid-stretch, act while down, relink without act.
        for (int c = 0; c < 30; c++)
            apply(1'b1, (c >= 6 && c < 14) ? 8'h01 : 8'h05, (c == 3 || c == 9) ? 8'h04 : 8'h00,
                  '0, 1'b0, 1'b0);

        // Overrides with link down, then lamp test over force-off, then release.
        for (int c = 0; c < 36; c++) begin
            md = {NP{(c < 10) ? 2'b01 : (c < 20) ? 2'b10 : (c < 28) ? 2'b11 : 2'b01}};
            apply(1'b1, '0, '0, md, (c >= 30 && c < 33), 1'b0);
        end

        // Sync landing exactly on the divider wrap.
        for (int c = 0; c < 40; c++)
            apply(1'b1, 8'h0F, '0, '0, 1'b0, (m_edges % BD) == BD - 1 && (c % 10) >= 5);

        lk = 8'hFF; md = '0; lt = 1'b0;
        for (int c = 0; c < 1600; c++) begin
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(31) == 0) lk[i] = ~lk[i];
                ac[i] = ($urandom_range(9) == 0);
                if ($urandom_range(63) == 0)
                    md[2*i +: 2] = ($urandom_range(2) == 0) ? 2'($urandom_range(3)) : 2'b00;
            end
            if ($urandom_range(59) == 0) lt = ~lt;
            sy = ($urandom_range(39) == 0);
            rs = !(c >= 700 && c < 703);
            apply(rs, lk, ac, md, lt, sy);
        end

        @(posedge clk);
        #2;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
